// File: rtl/run_det_arb.sv
// Shared run-of-ones detector time-multiplexed across N_CH serial requesters.
// A round-robin arbiter picks one channel per cycle; that channel's run context is updated and its result is reported one cycle later.
module run_det_arb #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned RUN_LEN = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] bit_i,
  output logic [N_CH-1:0] gnt_o,
  output logic            z_vld_o,
  output logic [CH_W-1:0] z_ch_o,
  output logic            z_o,
  output logic [N_CH-1:0] det_o
);

  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  det_q, det_d;
  logic             z_vld_q, z_vld_d;
  logic [CH_W-1:0]  z_ch_q, z_ch_d;
  logic             z_q, z_d;

  logic [N_CH-1:0]  gnt_c;
  logic             gnt_any;
  logic [CH_W-1:0]  gnt_idx;
  int unsigned      idx;
  logic [CNT_W-1:0] new_cnt;
  logic             new_det;

  // Round-robin search starting at the pointer; clear and reset suppress grants.
  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (rst_n && !clr_i) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        idx = 32'(ptr_q) + i;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_any && req_i[CH_W'(idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = CH_W'(idx);
        end
      end
      if (gnt_any) gnt_c[gnt_idx] = 1'b1;
    end
  end

  // Context, pointer and result next-state.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    det_d   = det_q;
    z_vld_d = 1'b0;
    z_ch_d  = z_ch_q;
    z_d     = z_q;
    new_cnt = '0;
    new_det = 1'b0;
    if (clr_i) begin
      ptr_d = '0;
      for (int unsigned k = 0; k < N_CH; k++) cnt_d[k] = '0;
      det_d  = '0;
      z_ch_d = '0;
      z_d    = 1'b0;
    end else if (gnt_any) begin
      if (bit_i[gnt_idx]) begin
        new_cnt = (cnt_q[gnt_idx] >= CNT_W'(RUN_LEN)) ? CNT_W'(RUN_LEN)
                                                      : cnt_q[gnt_idx] + CNT_W'(1);
      end
      new_det         = (new_cnt == CNT_W'(RUN_LEN));
      cnt_d[gnt_idx]  = new_cnt;
      det_d[gnt_idx]  = new_det;
      z_vld_d         = 1'b1;
      z_ch_d          = gnt_idx;
      z_d             = new_det;
      ptr_d           = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int unsigned k = 0; k < N_CH; k++) cnt_q[k] <= '0;
      det_q   <= '0;
      z_vld_q <= 1'b0;
      z_ch_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      z_vld_q <= z_vld_d;
      z_ch_q  <= z_ch_d;
      z_q     <= z_d;
    end
  end

  assign gnt_o   = gnt_c;
  assign z_vld_o = z_vld_q;
  assign z_ch_o  = z_ch_q;
  assign z_o     = z_q;
  assign det_o   = det_q;

endmodule

// File: tb/tb_run_det_arb.sv
// Scoreboard bench for run_det_arb: a run-length reference model predicts grants, detect levels and tagged results.
module tb_run_det_arb;
  localparam int unsigned N_CH    = 4;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned RUN_LEN = 2;
  localparam int unsigned CNT_W   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clr_i;
  logic [N_CH-1:0] req_i;
  logic [N_CH-1:0] bit_i;
  logic [N_CH-1:0] gnt_o;
  logic            z_vld_o;
  logic [CH_W-1:0] z_ch_o;
  logic            z_o;
  logic [N_CH-1:0] det_o;

  run_det_arb #(.N_CH(N_CH), .CH_W(CH_W), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .req_i(req_i), .bit_i(bit_i),
    .gnt_o(gnt_o), .z_vld_o(z_vld_o), .z_ch_o(z_ch_o), .z_o(z_o), .det_o(det_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: unbounded run length per channel, detect when run reaches RUN_LEN.
  int run_len [N_CH];
  int ptr_m;
  typedef struct { int ch; bit z; } exp_t;
  exp_t sb_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_CH-1:0] model_det();
    logic [N_CH-1:0] d;
    for (int k = 0; k < N_CH; k++) d[k] = (run_len[k] >= RUN_LEN);
    return d;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_CH; k++) run_len[k] = 0;
    ptr_m = 0;
  endtask

  // Drive one cycle at posedge+1, predict and check at negedge, return to posedge+1.
  task automatic step(input logic [N_CH-1:0] req, input logic [N_CH-1:0] bits,
                      input logic clr, output int granted);
    logic [N_CH-1:0] exp_gnt;
    exp_t e;
    req_i = req; bit_i = bits; clr_i = clr;
    granted = -1;
    @(negedge clk);
    chk("det_o", int'(det_o), int'(model_det()));
    if (!clr) begin
      for (int i = 0; i < N_CH; i++) begin
        int k;
        k = (ptr_m + i) % N_CH;
        if (granted < 0 && req[k]) granted = k;
      end
    end
    exp_gnt = '0;
    if (granted >= 0) exp_gnt[granted] = 1'b1;
    chk("gnt_o", int'(gnt_o), int'(exp_gnt));
    if (clr) begin
      model_clear();
    end else if (granted >= 0) begin
      run_len[granted] = bits[granted] ? run_len[granted] + 1 : 0;
      ptr_m = (granted + 1) % N_CH;
      e.ch = granted;
      e.z  = (run_len[granted] >= RUN_LEN);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    req_i = '1; bit_i = '1; clr_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst z_vld_o", int'(z_vld_o), 0);
    chk("rst z_o", int'(z_o), 0);
    chk("rst z_ch_o", int'(z_ch_o), 0);
    chk("rst det_o", int'(det_o), 0);
    chk("rst gnt_o", int'(gnt_o), 0);
    model_clear();
    sb_q.delete();
    req_i = '0; bit_i = '0;
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop one expectation per valid result; check hold on idle cycles.
  int  last_ch = 0;
  bit  last_z  = 0;
  bit  prev_clr = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ch = 0; last_z = 0; prev_clr = 0;
    end else begin
      if (prev_clr) begin
        last_ch = 0; last_z = 0;
        chk("clr z_vld_o", int'(z_vld_o), 0);
      end
      if (z_vld_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected result", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("z_ch_o", int'(z_ch_o), e.ch);
          chk("z_o", int'(z_o), int'(e.z));
          last_ch = e.ch; last_z = e.z;
        end
      end else begin
        chk("hold z_ch_o", int'(z_ch_o), last_ch);
        chk("hold z_o", int'(z_o), int'(last_z));
      end
      prev_clr = clr_i;
    end
  end

  initial begin
    int g;
    logic [N_CH-1:0] pend, pbit, bits;
    rst_n = 1'b0; clr_i = 1'b0; req_i = '0; bit_i = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Build ch0 run to saturation, then reset mid-operation; run restarts.
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    do_reset();
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0000, 4'b0000, 1'b0, g);

    // Channel 0 alone: 1,1,1,0,1.
    step(4'b0000, 4'b0000, 1'b1, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0000, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b0, g);

    // All channels requesting with ones: round-robin rotation.
    step(4'b0000, 4'b0000, 1'b1, g);
    for (int i = 0; i < 9; i++) step(4'b1111, 4'b1111, 1'b0, g);

    // Interleave ch1 and ch2.
    step(4'b0000, 4'b0000, 1'b1, g);
    step(4'b0010, 4'b0010, 1'b0, g);
    step(4'b0100, 4'b0000, 1'b0, g);
    step(4'b0010, 4'b0010, 1'b0, g);

    // Sparse requests 1010 held, then idle cycles.
    step(4'b0000, 4'b0000, 1'b1, g);
    for (int i = 0; i < 3; i++) step(4'b1010, 4'b1010, 1'b0, g);
    step(4'b0000, 4'b0000, 1'b0, g);
    step(4'b0000, 4'b0000, 1'b0, g);

    // Clear with pending ch0 request after saturating ch0.
    step(4'b0000, 4'b0000, 1'b1, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b0, g);
    step(4'b0001, 4'b0001, 1'b1, g);
    step(4'b0001, 4'b0001, 1'b0, g);

    // Randomized traffic honouring hold-until-granted, with clears and one reset.
    pend = '0; pbit = '0;
    for (int it = 0; it < 600; it++) begin
      if (it == 300) begin
        do_reset();
        pend = '0;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
          pend[k] = 1'b1;
          pbit[k] = ($urandom_range(0, 3) != 0);
        end
      end
      bits = N_CH'($urandom);
      for (int k = 0; k < N_CH; k++) if (pend[k]) bits[k] = pbit[k];
      step(pend, bits, ($urandom_range(0, 24) == 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end

    step(4'b0000, 4'b0000, 1'b0, g);
    step(4'b0000, 4'b0000, 1'b0, g);
    chk("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/run_det_arb.md
Name: run_det_arb

Overview:
Shared run-of-ones detection engine time-multiplexed among N_CH serial requesters. Each requester presents one sample bit per request. A round-robin arbiter grants one channel per cycle. The engine updates that channel's saved run-count context and reports the detect result tagged with the channel id. With RUN_LEN=2 each channel behaves as an independent two-consecutive-ones detector; the block replaces per-stream detector instances with one arbitrated engine.

Parameters:
N_CH, 4, number of requesting channels (>=2)
CH_W, 2, channel id width, = ceil(log2(N_CH))
RUN_LEN, 2, consecutive 1 samples required to assert detect (>=1)
CNT_W, 2, per-channel run counter width; must represent RUN_LEN

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr_i  input  1  synchronous clear of all channel contexts and pointer
req_i  input  N_CH  per-channel request; bit k held high until gnt_o[k] is sampled high
bit_i  input  N_CH  per-channel sample bit; bit_i[k] valid while req_i[k] high
gnt_o  output  N_CH  one-hot grant, combinational from req_i, pointer and clr_i
z_vld_o  output  1  result valid, one cycle after grant
z_ch_o  output  CH_W  channel id of result
z_o  output  1  detect result for z_ch_o
det_o  output  N_CH  registered current detect level of every channel

Behaviour:
- Reset (rst_n low, async): all cnt[k]=0, det_o=0, pointer=0, z_vld_o=0, z_ch_o=0, z_o=0. gnt_o=0 while in reset.
- Arbitration: search req_i starting at pointer, wrapping at N_CH-1 to 0. The first set bit k is granted (gnt_o[k]=1). No request gives gnt_o=0.
- Handshake: the transfer for channel k occurs on the rising edge where gnt_o[k]=1. The requester may then drop req_i[k] or present its next bit. Back-to-back requests from one channel are allowed.
- Pointer update: after a grant to k, pointer <= (k+1) mod N_CH. With no grant the pointer is unchanged.
- Context update on a grant to k:
  - bit_i[k]=1: cnt[k] <= min(cnt[k]+1, RUN_LEN), saturating at RUN_LEN.
  - bit_i[k]=0: cnt[k] <= 0.
  - det_o[k] <= (new cnt[k] == RUN_LEN).
  - Ungranted contexts hold.
- Result latency: 1 cycle. On the edge of a grant to k, z_vld_o<=1, z_ch_o<=k, z_o<=new det value.
- Cycle with no grant: z_vld_o<=0; z_ch_o and z_o hold their last values.
- RUN_LEN=1: det equals the granted bit.
- clr_i high (synchronous, highest priority):
  - gnt_o forced 0 that cycle.
  - Next edge: all cnt=0, det_o=0, pointer=0, z_vld_o=0, z_o=0, z_ch_o=0.
  - Pending requests stay pending.
- Simultaneous requests: exactly one grant per cycle. Each continuously requesting channel is granted at least once every N_CH cycles.
- Reset mid-operation: all context is lost and outputs return to reset values immediately. After release, the first grant goes to the lowest-indexed requester.
- Channel state is per-channel only. A 0 on one channel never affects another channel's count.

Test Plan:
1. Assert rst_n=0 while cnt[0]=2 and z_o=1 -> outputs go to 0 immediately. After release, req_i=0001, bit=1 gives z_o=0 (count restarted).
2. Channel 0 alone, bits 1,1,1,0,1 on consecutive grants -> z_vld_o=1 each following cycle, z_ch_o=0, z_o=0,1,1,0,0, det_o[0] tracks z_o.
3. req_i=1111 held, all bits=1 -> gnt_o cycles 0001,0010,0100,1000,0001. Each channel's z_o is 0 on its first grant and 1 on its second.
4. Interleave: ch1 bit=1, ch2 bit=0, ch1 bit=1 -> z results (ch1,0),(ch2,0),(ch1,1). Ch1 context is preserved across ch2 activity.
5. Pointer=0, req_i=1010 held -> grants ch1 then ch3 then ch1. Idle cycle (req_i=0) -> z_vld_o=0, z_ch_o/z_o hold, pointer unchanged.
6. With cnt[0]=2, pulse clr_i alongside req_i[0] -> gnt_o=0 that cycle. Next grant of ch0 with bit=1 gives z_o=0 and z_ch_o=0.
